row_readout_serializer: RTL
===========================

Name: row_readout_serializer

Overview:
- Downstream neighbour of the sensor top.
- Captures each converted pixel row (WIDTH x 8-bit column counter values) when the sensor state machine signals conversion complete for the selected row.
- Holds captured rows in a small row buffer and streams them out one pixel per cycle on a valid/ready interface tagged with row/column and frame/line markers.
- Decouples the fixed-timing sensor readout from a backpressuring consumer (frame store or host link).

Parameters:
PIXEL_ARRAY_WIDTH, 4, number of columns (pixels per row); >= 2
PIXEL_ARRAY_HEIGHT, 4, number of rows; >= 2
ROW_BUFFER_DEPTH, 2, rows held in buffer; power of two, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
row_select  in  PIXEL_ARRAY_HEIGHT  one-hot row currently read; all-zero = no row
row_data  in  PIXEL_ARRAY_WIDTH*8  converted row; column c at bits [8c+7:8c]
row_valid  in  1  single-cycle strobe: row_data for row_select is final
out_data  out  8  pixel value
out_row  out  clog2(PIXEL_ARRAY_HEIGHT)  row index of out_data
out_col  out  clog2(PIXEL_ARRAY_WIDTH)  column index of out_data
out_sof  out  1  high with pixel (row 0, col 0)
out_eol  out  1  high with pixel col PIXEL_ARRAY_WIDTH-1
out_valid  out  1  output beat valid
out_ready  in  1  consumer accepts beat
overflow  out  1  sticky: a row was dropped, buffer full
sel_error  out  1  sticky: row_valid with row_select not exactly one-hot

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_row=0, out_col=0, out_sof=0, out_eol=0, overflow=0, sel_error=0. Buffer count, write/read pointers, column counter=0. FSM=IDLE. Reset mid-stream discards all buffered rows and the pending beat.
- Capture: row_valid=1 and row_select exactly one-hot:
  - count < DEPTH (registered value, before any same-cycle pop): write row_data and encoded row index to slot wr_ptr; wr_ptr+1 mod DEPTH; count+1.
  - count == DEPTH: row dropped, overflow<=1. A same-cycle pop does not rescue it.
- row_valid with row_select zero or multi-hot: no capture, sel_error<=1. Overflow check is not applied.
- Output register (stream-style):
  - Loads when (out_valid==0 or out_ready==1) and a pixel is available.
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - out_valid drops after acceptance if nothing is available.
- FSM:
  - IDLE: count>0 and register loadable -> load col 0 of slot rd_ptr; go STREAM.
  - STREAM: each load advances col. Loading col W-1 pops the slot (rd_ptr+1, count-1) in that cycle. Then:
    - count after pop > 0 -> next load is col 0 of the next slot, no bubble.
    - otherwise -> IDLE.
- Push and pop in the same cycle: count unchanged.
- Latency: row_valid at edge N into an empty buffer with an idle output -> out_valid=1, col 0, from edge N+1. Throughput is 1 pixel/cycle with out_ready=1.
- Markers: out_sof=1 iff row 0 col 0. out_eol=1 iff col W-1. Both are registered with the beat.
- Pointers and column counter wrap modulo their range; no output rows are reordered.
- overflow and sel_error clear only on reset.

Test Plan:
(W=4, H=4, DEPTH=2)
- Basic: reset, row_select=0001, row_data=0x44332211, row_valid pulse at edge 0, out_ready=1 -> beats at edges 1..4 of data 11,22,33,44; row 0; col 0..3; out_sof at edge 1 only; out_eol at edge 4 only; out_valid=0 at edge 5.
- Backpressure: as basic, out_ready=0 for 3 cycles after first acceptance -> out_data=0x22, col=1 held stable for 3 cycles; all 4 pixels delivered once, in order.
- Overflow: out_ready=0, row_valid for rows 0,1,2 on edges 0,1,2 -> rows 0,1 buffered, row 2 dropped, overflow=1 from edge 3. Raising out_ready yields exactly 8 beats (rows 0 then 1).
- Select error: row_select=0011 with row_valid -> no capture, sel_error=1 next edge, out_valid stays 0, overflow stays 0.
- Back-to-back: out_ready=1, row_valid rows 2 and 3 on edges 0 and 1 -> 8 contiguous beats edges 1..8, rows 2 then 3, out_eol at edges 4 and 8, out_sof never.
- Reset mid-stream: assert reset while col 2 of a row is presented -> all outputs zero immediately, including flags. After release, a new row_valid streams normally from col 0.

Source files
------------

// File: rtl/row_readout_serializer.sv
// Row readout serializer: buffers converted sensor rows and streams them out
// one pixel per beat on a valid/ready interface with row/column and SOF/EOL tags.
module row_readout_serializer #(
  parameter int PIXEL_ARRAY_WIDTH  = 4,
  parameter int PIXEL_ARRAY_HEIGHT = 4,
  parameter int ROW_BUFFER_DEPTH   = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [PIXEL_ARRAY_HEIGHT-1:0]         row_select,
  input  logic [PIXEL_ARRAY_WIDTH*8-1:0]        row_data,
  input  logic                                  row_valid,
  output logic [7:0]                            out_data,
  output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0] out_row,
  output logic [$clog2(PIXEL_ARRAY_WIDTH)-1:0]  out_col,
  output logic                                  out_sof,
  output logic                                  out_eol,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  overflow,
  output logic                                  sel_error
);

  localparam int W  = PIXEL_ARRAY_WIDTH;
  localparam int H  = PIXEL_ARRAY_HEIGHT;
  localparam int D  = ROW_BUFFER_DEPTH;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);
  localparam int PW = $clog2(D);
  localparam int NW = PW + 1;
  localparam logic [NW-1:0] DEPTH_N  = NW'(D);
  localparam logic [CW-1:0] LAST_COL = CW'(W - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic [CW-1:0]   col_q, col_d;
  logic [7:0]      out_data_q, out_data_d;
  logic [RW-1:0]   out_row_q, out_row_d;
  logic [CW-1:0]   out_col_q, out_col_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eol_q, out_eol_d;
  logic            out_valid_q, out_valid_d;
  logic            overflow_q, overflow_d;
  logic            sel_error_q, sel_error_d;

  logic [7:0]      pix_mem [D][W];
  logic [RW-1:0]   row_mem [D];

  logic            sel_onehot;
  logic [RW-1:0]   sel_idx;
  logic            push, drop, pop, load_ok, do_load;
  logic [CW-1:0]   ld_col;

  // Row select decode: one-hot test and binary row index.
  always_comb begin
    sel_onehot = (row_select != '0) && ((row_select & (row_select - H'(1))) == '0);
    sel_idx    = '0;
    for (int i = 0; i < H; i++) begin
      if (row_select[i]) sel_idx = RW'(i);
    end
  end

  // Capture decisions use the registered count, so a same-cycle pop never frees a slot early.
  assign push = row_valid && sel_onehot && (count_q != DEPTH_N);
  assign drop = row_valid && sel_onehot && (count_q == DEPTH_N);

  assign load_ok = !out_valid_q || out_ready;
  assign do_load = load_ok && (count_q != '0);
  assign ld_col  = (state_q == IDLE) ? '0 : col_q;

  // NOTE: every signal written in a combinational block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    rd_ptr_d    = rd_ptr_q;
    pop         = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;

    if (load_ok) begin
      out_valid_d = do_load;
    end
    if (do_load) begin
      out_data_d = pix_mem[rd_ptr_q][ld_col];
      out_row_d  = row_mem[rd_ptr_q];
      out_col_d  = ld_col;
      out_sof_d  = (row_mem[rd_ptr_q] == '0) && (ld_col == '0);
      out_eol_d  = (ld_col == LAST_COL);
    end

    case (state_q)
      IDLE: begin
        if (do_load) begin
          col_d   = CW'(1);
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (do_load) begin
          if (col_q == LAST_COL) begin
            pop      = 1'b1;
            col_d    = '0;
            rd_ptr_d = rd_ptr_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Finishing the last buffered row returns to IDLE; otherwise the next row follows without a bubble.
    if (pop && (count_d == '0)) state_d = IDLE;

    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    overflow_d  = overflow_q | drop;
    sel_error_d = sel_error_q | (row_valid && !sel_onehot);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      col_q       <= '0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      sel_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      col_q       <= col_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      sel_error_q <= sel_error_d;
    end
  end

  // NOTE: the row buffer is not reset; a slot is only read after count shows it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      row_mem[wr_ptr_q] <= sel_idx;
      for (int c = 0; c < W; c++) begin
        pix_mem[wr_ptr_q][c] <= row_data[c*8 +: 8];
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign sel_error = sel_error_q;

endmodule
